key_debounce: RTL and testbench

//  Front-end conditioner for the defuser panel inputs (k1..k5, start).
//  - Synchronises each raw push-button/switch to clk.
//  - Filters contact bounce and emits clean levels plus 1-cycle press/release pulses.
//  - Reports the index of the key pressed each cycle.
//  - Sits between the board pins and the key/LED matcher and start latch.

---
 rtl/key_debounce_pkg.sv | 16 +
 rtl/key_debounce_filter_ch.sv | 78 +++++++
 rtl/key_debounce.sv | 62 ++++++
 tb/tb_key_debounce.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the panel key debouncer and its per-channel filters.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        S_LO   = 2'b00,
        CHK_HI = 2'b01,
        S_HI   = 2'b11,
        CHK_LO = 2'b10
    } state_t;

    localparam int KEY_CODE_W       = 3;
    localparam int DEF_N_KEYS       = 6;
    localparam int DEF_TICK_DIV     = 1000;
    localparam int DEF_STABLE_TICKS = 20;

endpackage

// File: rtl/key_debounce_filter_ch.sv
// One debounce channel: 2-FF synchroniser, four-state acceptance FSM with a tick
// counter, and registered level/press/release outputs.
module key_filter_ch
    import key_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = $clog2(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             r_meta;
    logic             r_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_state   <= S_LO;
            r_cnt     <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;

            // A bounce is tested before the tick, so it wins over an accept on the same cycle.
            case (r_state)
                S_LO: begin
                    if (r_sync) begin
                        r_state <= CHK_HI;
                        r_cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!r_sync) begin
                        r_state <= S_LO;
                    end else if (i_tick) begin
                        if (r_cnt == CNT_LAST) r_state <= S_HI;
                        else                   r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                S_HI: begin
                    if (!r_sync) begin
                        r_state <= CHK_LO;
                        r_cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (r_sync) begin
                        r_state <= S_HI;
                    end else if (i_tick) begin
                        if (r_cnt == CNT_LAST) r_state <= S_LO;
                        else                   r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_LO;
            endcase

            // State bit 1 is the accepted level (S_HI and CHK_LO); edges on it are the pulses.
            o_level   <= r_state[1];
            o_press   <= r_state[1] & ~o_level;
            o_release <= ~r_state[1] & o_level;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Panel input conditioner: shared sample-tick prescaler, one filter per key, and
// the press priority encoder / multi-press flag.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS       = DEF_N_KEYS,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_KEYS-1:0]     i_key_raw,
    output logic [N_KEYS-1:0]     o_key_level,
    output logic [N_KEYS-1:0]     o_key_press,
    output logic [N_KEYS-1:0]     o_key_release,
    output logic                  o_key_valid,
    output logic [KEY_CODE_W-1:0] o_key_code,
    output logic                  o_multi_press
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]      r_div;
    logic                  w_tick;
    logic [KEY_CODE_W-1:0] w_code;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst)       r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + DIV_W'(1);
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_filter_ch #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_raw     (i_key_raw[g]),
            .i_tick    (w_tick),
            .o_level   (o_key_level[g]),
            .o_press   (o_key_press[g]),
            .o_release (o_key_release[g])
        );
    end

    // Scan high to low so the lowest pressed index is the one left standing.
    always_comb begin
        w_code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (o_key_press[i]) w_code = KEY_CODE_W'(i);
        end
    end

    assign o_key_valid   = |o_key_press;
    assign o_key_code    = w_code;
    assign o_multi_press = |(o_key_press & (o_key_press - N_KEYS'(1)));

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulse events, a
// negedge monitor pops and compares them whenever a press/release pulse appears.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] key_raw = 6'h3F;
    logic [5:0] key_level, key_press, key_release;
    logic       key_valid, multi_press;
    logic [2:0] key_code;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [5:0] press;
        logic [5:0] rel;
        logic [5:0] level;
        logic       valid;
        logic [2:0] code;
        logic       multi;
        int         t0;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [5:0] exp_level = 6'h00;

    key_debounce #(
        .N_KEYS       (6),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_raw     (key_raw),
        .o_key_level   (key_level),
        .o_key_press   (key_press),
        .o_key_release (key_release),
        .o_key_valid   (key_valid),
        .o_key_code    (key_code),
        .o_multi_press (multi_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_rng(input string nm, input int v, input int lo, input int hi);
        n_checks++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d..%0d", nm, v, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [5:0] p, input logic [5:0] r, input logic [5:0] lvl,
                        input logic v, input logic [2:0] c, input logic m);
        exp_t x;
        x.press = p; x.rel = r; x.level = lvl;
        x.valid = v; x.code = c; x.multi = m; x.t0 = cyc;
        q.push_back(x);
    endtask

    task automatic all_zero(input string nm);
        check(nm, {key_level, key_press, key_release, key_valid, key_code, multi_press}, 32'h0);
    endtask

    // Monitor: every pulse must match the head of the queue, inside the latency window.
    always @(negedge clk) begin
        if ((key_press | key_release) !== 6'h00) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {key_press, key_release}, 32'h0);
            end else begin
                e = q.pop_front();
                check("press",   key_press,   e.press);
                check("release", key_release, e.rel);
                check("level",   key_level,   e.level);
                check("valid",   key_valid,   e.valid);
                check("code",    key_code,    e.code);
                check("multi",   multi_press, e.multi);
                check_rng("latency", cyc - e.t0, 12, 16);
                exp_level = e.level;
            end
        end else begin
            check("idle_outputs", {key_valid, key_code, multi_press, key_level},
                  {1'b0, 3'd0, 1'b0, exp_level});
        end
    end

    initial begin
        // Reset held with every key on: outputs stay zero.
        for (int i = 0; i < 3; i++) begin
            step(1);
            all_zero("reset_outputs");
        end
        rst = 1'b0;
        push(6'h3F, 6'h00, 6'h3F, 1'b1, 3'd0, 1'b1);
        step(20);
        check("timeout_hold_through_reset", q.size(), 0);

        key_raw = 6'h00;
        push(6'h00, 6'h3F, 6'h00, 1'b0, 3'd0, 1'b0);
        step(20);
        check("timeout_release_all", q.size(), 0);

        // Clean press on key 2.
        key_raw[2] = 1'b1;
        push(6'h04, 6'h00, 6'h04, 1'b1, 3'd2, 1'b0);
        step(40);
        check("timeout_press2", q.size(), 0);
        check("level2_held", key_level[2], 1'b1);

        // Bounce on key 0: 3-cycle pulses never survive three ticks.
        for (int i = 0; i < 10; i++) begin
            key_raw[0] = ~key_raw[0];
            step(3);
        end
        key_raw[0] = 1'b0;
        step(20);
        check("bounce_level0", key_level[0], 1'b0);

        // Release key 2.
        key_raw[2] = 1'b0;
        push(6'h00, 6'h04, 6'h00, 1'b0, 3'd0, 1'b0);
        step(20);
        check("timeout_release2", q.size(), 0);

        // Simultaneous press of keys 4 and 1.
        key_raw = 6'b010010;
        push(6'b010010, 6'h00, 6'b010010, 1'b1, 3'd1, 1'b1);
        step(20);
        check("timeout_simultaneous", q.size(), 0);
        key_raw = 6'h00;
        push(6'h00, 6'b010010, 6'h00, 1'b0, 3'd0, 1'b0);
        step(20);
        check("timeout_release_41", q.size(), 0);

        // Reset mid-filter on key 3: progress discarded, fresh press afterwards.
        key_raw[3] = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        all_zero("midfilter_reset_outputs");
        rst = 1'b0;
        push(6'h08, 6'h00, 6'h08, 1'b1, 3'd3, 1'b0);
        step(20);
        check("timeout_press3_after_reset", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
